// File: rtl/rr_grant_manager.sv
// Round-robin grant owner: registers a one-hot grant, holds it while the winner requests,
// rotates the priority base on release, and optionally revokes long holds. Optional lock input under RR_GRANT_LOCK_EN.
module rr_grant_manager #(
   parameter int WIDTH    = 16,
   parameter int IDX_W    = 4,
   parameter int MAX_HOLD = 255,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] req,
`ifdef RR_GRANT_LOCK_EN
   input  logic             lock,
`endif
   output logic [WIDTH-1:0] grant,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_idx,
   output logic [WIDTH-1:0] base,
   output logic             timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t             r_state, w_nstate;
   logic [WIDTH-1:0]   r_grant, w_ngrant;
   logic               r_valid, w_nvalid;
   logic [IDX_W-1:0]   r_idx, w_nidx;
   logic [WIDTH-1:0]   r_base, w_nbase;
   logic [CNT_W-1:0]   r_cnt, w_ncnt;
   logic               r_timeout, w_ntimeout;

   logic [2*WIDTH-1:0] w_dbl, w_dbl_gnt;
   logic [WIDTH-1:0]   w_win;
   logic [IDX_W-1:0]   w_win_idx;
   logic               w_release, w_expire, w_lock;

   // Subtracting base from the doubled request borrows up to the first set bit at/above base.
   assign w_dbl     = {req, req};
   assign w_dbl_gnt = w_dbl & ~(w_dbl - {{WIDTH{1'b0}}, r_base});
   assign w_win     = w_dbl_gnt[2*WIDTH-1:WIDTH] | w_dbl_gnt[WIDTH-1:0];

   always_comb begin
      w_win_idx = '0;
      for (int i = 0; i < WIDTH; i++)
         if (w_win[i]) w_win_idx = w_win_idx | IDX_W'(i);
   end

`ifdef RR_GRANT_LOCK_EN
   assign w_lock = lock;
`else
   assign w_lock = 1'b0;
`endif

   // >= so that a counter that ran past MAX_HOLD under lock expires as soon as lock drops.
   assign w_release = ((req & r_grant) == '0);
   assign w_expire  = (MAX_HOLD != 0) && (r_cnt >= CNT_W'(MAX_HOLD)) && !w_lock;

   always_comb begin
      w_nstate   = r_state;
      w_ngrant   = r_grant;
      w_nvalid   = r_valid;
      w_nidx     = r_idx;
      w_nbase    = r_base;
      w_ncnt     = r_cnt;
      w_ntimeout = 1'b0;
      case (r_state)
         IDLE: begin
            if (|req) begin
               w_nstate = GRANT;
               w_ngrant = w_win;
               w_nidx   = w_win_idx;
               w_nvalid = 1'b1;
               w_ncnt   = CNT_W'(1);
            end
         end
         GRANT: begin
            if (w_release || w_expire) begin
               w_nstate   = IDLE;
               w_ngrant   = '0;
               w_nvalid   = 1'b0;
               w_nidx     = '0;
               w_nbase    = {r_grant[WIDTH-2:0], r_grant[WIDTH-1]};
               w_ncnt     = '0;
               w_ntimeout = !w_release;
            end else if (r_cnt != {CNT_W{1'b1}}) begin
               w_ncnt = r_cnt + CNT_W'(1);
            end
         end
         default: w_nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_grant   <= '0;
         r_valid   <= 1'b0;
         r_idx     <= '0;
         r_base    <= WIDTH'(1);
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_nstate;
         r_grant   <= w_ngrant;
         r_valid   <= w_nvalid;
         r_idx     <= w_nidx;
         r_base    <= w_nbase;
         r_cnt     <= w_ncnt;
         r_timeout <= w_ntimeout;
      end
   end

   assign grant       = r_grant;
   assign grant_valid = r_valid;
   assign grant_idx   = r_idx;
   assign base        = r_base;
   assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_grant_manager.sv
// Directed bench for rr_grant_manager with MAX_HOLD=4; covers reset, rotation, wrap, timeout and lock.
module tb_rr_grant_manager;
   localparam int WIDTH = 16;
   localparam int IDX_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] req = '0;
   logic             lock = 1'b0;
   logic [WIDTH-1:0] grant, base;
   logic             grant_valid, timeout;
   logic [IDX_W-1:0] grant_idx;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rr_grant_manager #(.WIDTH(WIDTH), .IDX_W(IDX_W), .MAX_HOLD(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .req(req),
`ifdef RR_GRANT_LOCK_EN
      .lock(lock),
`endif
      .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx),
      .base(base), .timeout(timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      step();
      step();
      rst = 1'b0;
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_valid", 32'(grant_valid), 32'h0);
      chk("rst_idx", 32'(grant_idx), 32'h0);
      chk("rst_base", 32'(base), 32'h1);
      chk("rst_timeout", 32'(timeout), 32'h0);

      // basic rotation
      req = 16'h0011;
      step();
      chk("rot_grant0", 32'(grant), 32'h1);
      chk("rot_idx0", 32'(grant_idx), 32'h0);
      chk("rot_valid0", 32'(grant_valid), 32'h1);
      req = 16'h0010;
      step();
      chk("rot_gap_grant", 32'(grant), 32'h0);
      chk("rot_gap_base", 32'(base), 32'h2);
      chk("rot_gap_timeout", 32'(timeout), 32'h0);
      step();
      chk("rot_grant4", 32'(grant), 32'h10);
      chk("rot_idx4", 32'(grant_idx), 32'h4);
      req = 16'h0000;
      step();
      chk("rot_rel_base", 32'(base), 32'h20);

      // wrap from bit 15
      req = 16'h8000;
      step();
      chk("wrap_grant15", 32'(grant), 32'h8000);
      chk("wrap_idx15", 32'(grant_idx), 32'hF);
      req = 16'h0000;
      step();
      chk("wrap_base", 32'(base), 32'h1);
      req = 16'h8004;
      step();
      chk("wrap_grant2", 32'(grant), 32'h4);
      chk("wrap_idx2", 32'(grant_idx), 32'h2);
      req = 16'h0000;
      step();
      chk("wrap_rel_base", 32'(base), 32'h8);

      // timeout after exactly 4 held cycles
      req = 16'h0002;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("to_hold_grant", 32'(grant), 32'h2);
         chk("to_hold_timeout", 32'(timeout), 32'h0);
      end
      step();
      chk("to_pulse", 32'(timeout), 32'h1);
      chk("to_grant", 32'(grant), 32'h0);
      chk("to_base", 32'(base), 32'h4);
      step();
      chk("to_regrant", 32'(grant), 32'h2);
      chk("to_pulse_end", 32'(timeout), 32'h0);

      // release on the same edge the counter reaches MAX_HOLD
      step();
      step();
      step();
      chk("sim_still_granted", 32'(grant), 32'h2);
      req = 16'h0000;
      step();
      chk("sim_grant", 32'(grant), 32'h0);
      chk("sim_timeout", 32'(timeout), 32'h0);
      chk("sim_base", 32'(base), 32'h4);

      // async reset mid-grant
      req = 16'h0010;
      step();
      chk("mid_grant", 32'(grant), 32'h10);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_grant", 32'(grant), 32'h0);
      chk("mid_rst_valid", 32'(grant_valid), 32'h0);
      chk("mid_rst_base", 32'(base), 32'h1);
      chk("mid_rst_timeout", 32'(timeout), 32'h0);
      req = 16'h0000;
      step();
      rst = 1'b0;
      step();
      chk("post_rst_grant", 32'(grant), 32'h0);

`ifdef RR_GRANT_LOCK_EN
      lock = 1'b1;
      req  = 16'h0002;
      step();
      for (int i = 0; i < 10; i++) begin
         chk("lock_grant", 32'(grant), 32'h2);
         chk("lock_timeout", 32'(timeout), 32'h0);
         if (i < 9) step();
      end
      lock = 1'b0;
      step();
      chk("lock_drop_timeout", 32'(timeout), 32'h1);
      chk("lock_drop_grant", 32'(grant), 32'h0);
      chk("lock_drop_base", 32'(base), 32'h4);
      req = 16'h0000;
      step();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
